// File: rtl/alu_seq.sv
// alu_seq: multi-cycle unsigned ALU with a start/busy/done handshake.
//
// A request is accepted on a rising edge where start=1 and the block is idle.
// op, a and b are latched at that edge. Logic, add and shift ops take a single
// execute step. MUL (shift-add) and DIV (restoring) take WIDTH steps, one
// partial product or quotient bit per step. The result and flags are then
// registered into the outputs and done pulses for one cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset; aborts any request in flight
//   start   request strobe, sampled only while idle
//   op      opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR,
//           8 MUL, 9 DIV, 10-15 illegal)
//   a, b    WIDTH-bit unsigned operands
//   busy    high from the accepting edge until the done cycle ends
//   done    one-cycle pulse; result and flags are valid
//   result  2*WIDTH-bit registered result; holds until the next done
//   carry   ADD carry-out or SUB borrow
//   zero    result is all zeros
//   err     divide by zero or illegal opcode
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpMul = 4'd8;
  localparam logic [3:0] OpDiv = 4'd9;

  localparam logic [WIDTH-1:0] ShiftLimit = WIDTH'(WIDTH);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;         // MUL shifts this right as the multiplier
  logic [CntW-1:0]      cnt_q, cnt_d;     // execute steps completed
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // product, or {remainder, quotient} for DIV
  logic [2*WIDTH-1:0]   mcand_q, mcand_d; // MUL multiplicand, shifted left each step
  logic                 cy_q, cy_d;
  logic                 er_q, er_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

  // Execute-step helpers
  logic [CntW-1:0]      n_steps;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       trial;

  always_comb begin
    // Iterative ops need WIDTH steps; everything else (including DIV by 0) needs one.
    if (op_q == OpMul || (op_q == OpDiv && b_q != '0)) begin
      n_steps = CntW'(WIDTH);
    end else begin
      n_steps = CntW'(1);
    end

    sum    = {1'b0, a_q} + {1'b0, b_q};
    diff   = {1'b0, a_q} - {1'b0, b_q};
    // Restoring divide: shift the next dividend bit into the partial remainder
    // and subtract the divisor; a clear sign bit means the subtraction stands.
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_q};

    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cy_d     = cy_q;
    er_d     = er_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StExec;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          acc_d   = (op == OpDiv) ? {{WIDTH{1'b0}}, a} : '0;
          mcand_d = {{WIDTH{1'b0}}, a};
          cy_d    = 1'b0;
          er_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      StExec: begin
        if (cnt_q == n_steps) begin
          state_d  = StDone;
          result_d = acc_q;
          carry_d  = cy_q;
          err_d    = er_q;
          zero_d   = (acc_q == '0);
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          case (op_q)
            OpAdd: begin
              acc_d = {{(WIDTH-1){1'b0}}, sum};
              cy_d  = sum[WIDTH];
            end
            OpSub: begin
              acc_d = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
              cy_d  = diff[WIDTH];
            end
            OpAnd: acc_d = {{WIDTH{1'b0}}, a_q & b_q};
            OpOr:  acc_d = {{WIDTH{1'b0}}, a_q | b_q};
            OpXor: acc_d = {{WIDTH{1'b0}}, a_q ^ b_q};
            OpNot: acc_d = {{WIDTH{1'b0}}, ~a_q};
            OpShl: acc_d = (b_q >= ShiftLimit) ? '0 : {{WIDTH{1'b0}}, a_q << b_q};
            OpShr: acc_d = (b_q >= ShiftLimit) ? '0 : {{WIDTH{1'b0}}, a_q >> b_q};
            OpMul: begin
              if (b_q[0]) begin
                acc_d = acc_q + mcand_q;
              end
              mcand_d = mcand_q << 1;
              b_d     = b_q >> 1;
            end
            OpDiv: begin
              if (b_q == '0) begin
                acc_d = {a_q, {WIDTH{1'b1}}};
                er_d  = 1'b1;
              end else if (!trial[WIDTH]) begin
                acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
              end else begin
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
              end
            end
            default: begin
              acc_d = '0;
              er_d  = 1'b1;
            end
          endcase
        end
      end

      StDone: begin
        state_d = StIdle;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cy_q     <= 1'b0;
      er_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cy_q     <= cy_d;
      er_q     <= er_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): directed vector table, randomized requests
// against an arithmetic reference model, and hand-written busy/reset sequences.
module tb_alu_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned RW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          carry;
  logic          zero;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
    .zero   (zero),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] res;
    logic          c;
    logic          z;
    logic          e;
    int            lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode definitions.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [RW-1:0] r, output logic c, output logic z,
                       output logic e, output int lat);
    int unsigned ua = x;
    int unsigned ub = y;
    int unsigned m  = (1 << W) - 1;
    int unsigned v  = 0;
    c = 1'b0;
    e = 1'b0;
    lat = 2;
    case (o)
      4'd0: begin v = ua + ub; c = (v > m); end
      4'd1: begin v = (ua - ub) & m; c = (ua < ub); end
      4'd2: v = ua & ub;
      4'd3: v = ua | ub;
      4'd4: v = ua ^ ub;
      4'd5: v = ~ua & m;
      4'd6: v = (ub >= W) ? 0 : ((ua << ub) & m);
      4'd7: v = (ub >= W) ? 0 : (ua >> ub);
      4'd8: begin v = ua * ub; lat = W + 1; end
      4'd9: begin
        if (ub == 0) begin
          v = ua * (m + 1) + m;
          e = 1'b1;
        end else begin
          v = (ua % ub) * (m + 1) + ua / ub;
          lat = W + 1;
        end
      end
      default: begin v = 0; e = 1'b1; end
    endcase
    r = RW'(v);
    z = (v == 0);
  endtask

  // Issue one request, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [RW-1:0] r, output logic c, output logic z,
                        output logic e, output int lat);
    bit got_done = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 4'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        got_done = 1;
        break;
      end
    end
    if (!got_done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done, expected done within 40 cycles");
    end
    check("busy_with_done", {31'd0, busy}, {31'd0, got_done});
    r = result; c = carry; z = zero; e = err;
    @(posedge clk); #1;
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
    check("result_holds", {16'd0, result}, {16'd0, r});
  endtask

  task automatic run_and_compare(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic [RW-1:0] er,
                                 input logic ec, input logic ez, input logic ee, input int el);
    logic [RW-1:0] r;
    logic c, z, e;
    int lat;
    run_op(o, x, y, r, c, z, e, lat);
    check({tag, "_result"}, {16'd0, r}, {16'd0, er});
    check({tag, "_carry"}, {31'd0, c}, {31'd0, ec});
    check({tag, "_zero"}, {31'd0, z}, {31'd0, ez});
    check({tag, "_err"}, {31'd0, e}, {31'd0, ee});
    check({tag, "_latency"}, lat, el);
  endtask

  initial begin
    logic [RW-1:0] mr;
    logic mc, mz, me;
    int ml;
    int busy_cnt;
    int done_cnt;
    logic [RW-1:0] seen;

    //        op     a      b      result    c  z  e  lat
    vecs[0]  = '{4'd0, 8'd200, 8'd100, 16'h012C, 1, 0, 0, 2};
    vecs[1]  = '{4'd1, 8'd5,   8'd7,   16'h00FE, 1, 0, 0, 2};
    vecs[2]  = '{4'd1, 8'd9,   8'd9,   16'h0000, 0, 1, 0, 2};
    vecs[3]  = '{4'd8, 8'd255, 8'd255, 16'hFE01, 0, 0, 0, 9};
    vecs[4]  = '{4'd9, 8'd100, 8'd7,   16'h020E, 0, 0, 0, 9};
    vecs[5]  = '{4'd9, 8'd37,  8'd0,   16'h25FF, 0, 0, 1, 2};
    vecs[6]  = '{4'd6, 8'h81,  8'd1,   16'h0002, 0, 0, 0, 2};
    vecs[7]  = '{4'd7, 8'h80,  8'd9,   16'h0000, 0, 1, 0, 2};
    vecs[8]  = '{4'd12, 8'h55, 8'h33,  16'h0000, 0, 1, 1, 2};
    vecs[9]  = '{4'd5, 8'h0F,  8'd0,   16'h00F0, 0, 0, 0, 2};
    vecs[10] = '{4'd2, 8'hF0,  8'h3C,  16'h0030, 0, 0, 0, 2};
    vecs[11] = '{4'd4, 8'hAA,  8'hFF,  16'h0055, 0, 0, 0, 2};
    vecs[12] = '{4'd6, 8'h81,  8'd8,   16'h0000, 0, 1, 0, 2};
    vecs[13] = '{4'd8, 8'd0,   8'd77,  16'h0000, 0, 1, 0, 9};

    start = 1'b0; op = '0; a = '0; b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_outputs", {11'd0, busy, done, carry, zero, err, result}, 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_and_compare($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].e, vecs[i].lat);
    end

    for (int i = 0; i < 80; i++) begin
      logic [3:0] o;
      logic [W-1:0] x, y;
      o = 4'($urandom_range(0, 15));
      x = W'($urandom);
      y = W'($urandom);
      if (o == 4'd6 || o == 4'd7) y = W'($urandom_range(0, 10));
      if (o == 4'd9 && $urandom_range(0, 4) == 0) y = '0;
      model(o, x, y, mr, mc, mz, me, ml);
      run_and_compare($sformatf("rnd%0d_op%0d", i, o), o, x, y, mr, mc, mz, me, ml);
    end

    // MUL with inputs and start thrashing while busy: one done, result unchanged.
    @(negedge clk);
    op = 4'd8; a = 8'd255; b = 8'd255; start = 1'b1;
    @(posedge clk); #1;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    seen = '0;
    for (int i = 1; i <= 13; i++) begin
      if (i <= 10) begin
        start = ~start;
        a = W'($urandom);
        b = W'($urandom);
        op = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        seen = result;
        check("mul_busy_done_edge", i, 9);
      end
    end
    check("mul_busy_cycles", busy_cnt, 10);
    check("mul_done_count", done_cnt, 1);
    check("mul_busy_result", {16'd0, seen}, 32'h0000FE01);
    check("mul_result_after", {16'd0, result}, 32'h0000FE01);

    // Reset during the 4th execute cycle of a MUL aborts it.
    @(negedge clk);
    op = 4'd8; a = 8'd200; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {11'd0, busy, done, carry, zero, err, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("midreset_no_done", done_cnt, 0);
    check("midreset_no_busy", busy_cnt, 0);
    check("midreset_result_zero", {16'd0, result}, 32'd0);
    run_and_compare("post_reset_add", 4'd0, 8'd1, 8'd1, 16'h0002, 0, 0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
